// File: rtl/lpc_host_if.sv
// lpc_host_if: request/response handshake plus LPC pad signals of the LPC host.
//   master : view taken by lpc_host (drives req_ready, resp_*, LAD/LFRAME#)
//   slave  : view taken by the requester and the peripheral model
// Signals:
//   req_valid/req_ready        request handshake
//   req_cyctype_dir[3:0]       CYCTYPE+DIR nibble, [3:2] 00=I/O 01=memory, [1]=write
//   req_addr[31:0]             address (I/O uses [15:0])
//   req_data[7:0]              write data
//   resp_valid                 one-cycle completion pulse
//   resp_data[7:0]             read data, held until the next completion
//   resp_error/resp_timeout    completion status, valid with resp_valid
//   lpc_ad_in/out/oe           LAD[3:0] sample, drive value and output enable
//   lpc_frame                  LFRAME#, active low
interface lpc_host_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_cyctype_dir;
   logic [31:0] req_addr;
   logic [7:0]  req_data;
   logic        resp_valid;
   logic [7:0]  resp_data;
   logic        resp_error;
   logic        resp_timeout;
   logic [3:0]  lpc_ad_in;
   logic [3:0]  lpc_ad_out;
   logic        lpc_ad_oe;
   logic        lpc_frame;

   modport master (
      input  req_valid, req_cyctype_dir, req_addr, req_data, lpc_ad_in,
      output req_ready, resp_valid, resp_data, resp_error, resp_timeout,
             lpc_ad_out, lpc_ad_oe, lpc_frame
   );

   modport slave (
      output req_valid, req_cyctype_dir, req_addr, req_data, lpc_ad_in,
      input  req_ready, resp_valid, resp_data, resp_error, resp_timeout,
             lpc_ad_out, lpc_ad_oe, lpc_frame
   );
endinterface

// File: rtl/lpc_host.sv
// lpc_host: LPC bus initiator. Accepts one I/O or memory read/write request at
// a time, runs START/CYCTYPE/ADDR/DATA/TAR on LAD and LFRAME#, waits for the
// peripheral SYNC and returns read data and status.
// Parameters:
//   SYNC_TIMEOUT  non-terminal SYNC cycles allowed before abort
//   LONG_TIMEOUT  the same limit once a long-wait SYNC (0110) was seen
// Ports:
//   clock         LPC clock, rising edge
//   reset         synchronous, active low
//   bus           lpc_host_if.master (request, response and LAD/LFRAME# pads)
module lpc_host #(
   parameter int SYNC_TIMEOUT = 8,
   parameter int LONG_TIMEOUT = 1024
) (
   input logic        clock,
   input logic        reset,
   lpc_host_if.master bus
);

   localparam int MAX_LIM = (LONG_TIMEOUT > SYNC_TIMEOUT) ? LONG_TIMEOUT : SYNC_TIMEOUT;
   localparam int CNT_W   = $clog2(MAX_LIM + 1);
   localparam logic [CNT_W-1:0] SYNC_LIM = CNT_W'(SYNC_TIMEOUT);
   localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_TIMEOUT);

   localparam logic [3:0] ST_IDLE    = 4'd0;
   localparam logic [3:0] ST_START   = 4'd1;
   localparam logic [3:0] ST_CYCTYPE = 4'd2;
   localparam logic [3:0] ST_ADDR    = 4'd3;
   localparam logic [3:0] ST_HDATA   = 4'd4;
   localparam logic [3:0] ST_TAR_H   = 4'd5;
   localparam logic [3:0] ST_SYNC    = 4'd6;
   localparam logic [3:0] ST_PDATA   = 4'd7;
   localparam logic [3:0] ST_TAR_P   = 4'd8;
   localparam logic [3:0] ST_ABORT   = 4'd9;
   localparam logic [3:0] ST_DONE    = 4'd10;

   localparam logic [3:0] SYNC_READY = 4'b0000;
   localparam logic [3:0] SYNC_ERROR = 4'b1010;
   localparam logic [3:0] SYNC_LWAIT = 4'b0110;

   logic [3:0]       state_q, state_d;
   logic [3:0]       cyc_q, cyc_d;
   logic [31:0]      addr_sh_q, addr_sh_d;   // next address nibble always in [31:28]
   logic [7:0]       wdata_q, wdata_d;
   logic [7:0]       rdata_q, rdata_d;       // read data being assembled
   logic [7:0]       resp_data_q, resp_data_d;
   logic [2:0]       step_q, step_d;         // cycle index within the current phase
   logic [CNT_W-1:0] wait_q, wait_d;         // non-terminal SYNC cycles seen
   logic             long_q, long_d;
   logic             err_q, err_d;
   logic             tmo_q, tmo_d;
   logic             rst_done_q, rst_done_d;

   logic             req_ready;
   logic             req_accept;
   logic             is_write;
   logic             is_mem;
   logic             long_now;
   logic [CNT_W-1:0] wait_inc;
   logic             frame;
   logic             ad_oe;
   logic [3:0]       ad_out;

   assign req_ready  = rst_done_q && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign req_accept = bus.req_valid && req_ready;
   assign is_write   = cyc_q[1];
   assign is_mem     = cyc_q[2];

   always_comb begin
      // NOTE: every signal gets a default before the case so no path infers a latch.
      state_d     = state_q;
      cyc_d       = cyc_q;
      addr_sh_d   = addr_sh_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      resp_data_d = resp_data_q;
      step_d      = step_q;
      wait_d      = wait_q;
      long_d      = long_q;
      err_d       = err_q;
      tmo_d       = tmo_q;
      rst_done_d  = 1'b1;
      long_now    = long_q;
      wait_inc    = wait_q + CNT_W'(1);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (req_accept) begin
               cyc_d     = bus.req_cyctype_dir;
               // I/O cycles carry only 16 address bits; left-align them so the
               // ADDR phase always shifts out of the top nibble.
               addr_sh_d = bus.req_cyctype_dir[2] ? bus.req_addr
                                                  : {bus.req_addr[15:0], 16'h0000};
               wdata_d   = bus.req_data;
               step_d    = 3'd0;
               tmo_d     = 1'b0;
               // Types 10xx/11xx are not supported: finish at once with error.
               err_d     = bus.req_cyctype_dir[3];
               state_d   = bus.req_cyctype_dir[3] ? ST_DONE : ST_START;
            end
         end
         ST_START:   state_d = ST_CYCTYPE;
         ST_CYCTYPE: begin
            state_d = ST_ADDR;
            step_d  = 3'd0;
         end
         ST_ADDR: begin
            addr_sh_d = {addr_sh_q[27:0], 4'h0};
            step_d    = step_q + 3'd1;
            if (step_q == (is_mem ? 3'd7 : 3'd3)) begin
               step_d  = 3'd0;
               state_d = is_write ? ST_HDATA : ST_TAR_H;
            end
         end
         ST_HDATA: begin
            step_d = step_q + 3'd1;
            if (step_q == 3'd1) begin
               step_d  = 3'd0;
               state_d = ST_TAR_H;
            end
         end
         ST_TAR_H: begin
            step_d = step_q + 3'd1;
            if (step_q == 3'd1) begin
               step_d  = 3'd0;
               wait_d  = '0;
               long_d  = 1'b0;
               state_d = ST_SYNC;
            end
         end
         ST_SYNC: begin
            if ((bus.lpc_ad_in == SYNC_READY) || (bus.lpc_ad_in == SYNC_ERROR)) begin
               err_d   = (bus.lpc_ad_in == SYNC_ERROR);
               step_d  = 3'd0;
               state_d = is_write ? ST_TAR_P : ST_PDATA;
            end else begin
               // A long wait in this very sample already applies the long limit.
               long_now = long_q || (bus.lpc_ad_in == SYNC_LWAIT);
               long_d   = long_now;
               wait_d   = wait_inc;
               if (wait_inc == (long_now ? LONG_LIM : SYNC_LIM)) begin
                  step_d  = 3'd0;
                  state_d = ST_ABORT;
               end
            end
         end
         ST_PDATA: begin
            step_d = step_q + 3'd1;
            if (step_q == 3'd0) begin
               rdata_d[3:0] = bus.lpc_ad_in;
            end else begin
               rdata_d[7:4] = bus.lpc_ad_in;
               step_d       = 3'd0;
               state_d      = ST_TAR_P;
            end
         end
         ST_TAR_P: begin
            step_d = step_q + 3'd1;
            if (step_q == 3'd1) begin
               step_d  = 3'd0;
               // resp_data only moves together with resp_valid, and only for reads.
               if (!is_write) resp_data_d = rdata_q;
               state_d = ST_DONE;
            end
         end
         ST_ABORT: begin
            step_d = step_q + 3'd1;
            if (step_q == 3'd4) begin
               step_d  = 3'd0;
               tmo_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus pins are decoded from the registered state, so each phase is exactly
   // the cycles spent in that state.
   always_comb begin
      frame  = 1'b1;
      ad_oe  = 1'b0;
      ad_out = 4'hF;
      case (state_q)
         ST_START: begin
            frame  = 1'b0;
            ad_oe  = 1'b1;
            ad_out = 4'h0;
         end
         ST_CYCTYPE: begin
            ad_oe  = 1'b1;
            ad_out = cyc_q;
         end
         ST_ADDR: begin
            ad_oe  = 1'b1;
            ad_out = addr_sh_q[31:28];
         end
         ST_HDATA: begin
            ad_oe  = 1'b1;
            ad_out = step_q[0] ? wdata_q[7:4] : wdata_q[3:0];
         end
         ST_TAR_H: ad_oe = !step_q[0];   // drive 1111 then turn the bus around
         ST_ABORT: begin
            ad_oe = 1'b1;
            frame = (step_q == 3'd4);    // four cycles low, one recovery cycle high
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees
      // pre-edge values regardless of statement order.
      if (!reset) begin
         state_q     <= ST_IDLE;
         cyc_q       <= 4'h0;
         addr_sh_q   <= 32'h0;
         wdata_q     <= 8'h00;
         rdata_q     <= 8'h00;
         resp_data_q <= 8'h00;
         step_q      <= 3'd0;
         wait_q      <= '0;
         long_q      <= 1'b0;
         err_q       <= 1'b0;
         tmo_q       <= 1'b0;
         rst_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         addr_sh_q   <= addr_sh_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         resp_data_q <= resp_data_d;
         step_q      <= step_d;
         wait_q      <= wait_d;
         long_q      <= long_d;
         err_q       <= err_d;
         tmo_q       <= tmo_d;
         rst_done_q  <= rst_done_d;
      end
   end

   assign bus.req_ready    = req_ready;
   assign bus.resp_valid   = (state_q == ST_DONE);
   assign bus.resp_data    = resp_data_q;
   assign bus.resp_error   = err_q;
   assign bus.resp_timeout = tmo_q;
   assign bus.lpc_frame    = frame;
   assign bus.lpc_ad_oe    = ad_oe;
   assign bus.lpc_ad_out   = ad_out;

endmodule

// File: tb/tb_lpc_host.sv
// tb_lpc_host: self-checking bench for lpc_host. A table of directed requests
// with hand-derived completion values, a mid-cycle reset sequence and random
// requests. The expected LAD/LFRAME# trace and response of every request are
// built from the bus protocol rules as a list of per-cycle pin values.
`timescale 1ns/1ps
module tb_lpc_host;

   localparam int SYNC_TO = 8;
   localparam int LONG_TO = 1024;

   typedef struct packed {
      logic       frame;
      logic       oe;
      logic [3:0] ad;
   } bus_t;

   typedef struct {
      logic [3:0]  cyc;
      logic [31:0] addr;
      logic [7:0]  wdata;
      int          n_wait;     // SYNC cycles carrying wait_code before term
      logic [3:0]  wait_code;
      logic [3:0]  term;       // code after the waits (F repeats forever)
      logic [7:0]  rdata;      // peripheral read data
      int          exp_n;      // cycle of resp_valid; 0 = take from model
      bit          exp_err;
      bit          exp_tmo;
      logic [7:0]  exp_rdata;
   } vec_t;

   logic clock;
   logic reset;
   int   vectors;
   int   miscompares;
   logic [7:0] hold_data;      // resp_data the requester should currently see

   lpc_host_if bus_if ();

   lpc_host #(.SYNC_TIMEOUT(SYNC_TO), .LONG_TIMEOUT(LONG_TO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bus_t mk(input logic f, input logic o, input logic [3:0] a);
      bus_t b;
      b.frame = f;
      b.oe    = o;
      b.ad    = a;
      return b;
   endfunction

   function automatic vec_t mkv(input logic [3:0] cyc, input logic [31:0] addr,
                                input logic [7:0] wd, input int nw, input logic [3:0] wc,
                                input logic [3:0] term, input logic [7:0] rd,
                                input int en, input bit ee, input bit et, input logic [7:0] er);
      vec_t v;
      v.cyc = cyc; v.addr = addr; v.wdata = wd; v.n_wait = nw; v.wait_code = wc;
      v.term = term; v.rdata = rd; v.exp_n = en; v.exp_err = ee; v.exp_tmo = et;
      v.exp_rdata = er;
      return v;
   endfunction

   // Caller is positioned at a negedge where the DUT should be ready; on return
   // the bench sits at the negedge of the DONE cycle, so calls chain back-to-back.
   task automatic run_txn(input vec_t v);
      bus_t       exp_q[$];
      logic [3:0] drv_q[$];
      bus_t       e;
      logic [3:0] code;
      logic [7:0] m_data;
      int         cnt, exp_n, n_nib;
      bit         lng, aborted, term_seen, rd, m_err, m_tmo;

      rd = !v.cyc[1];
      cnt = 0; lng = 0; aborted = 0; term_seen = 0; m_err = 0; m_tmo = 0;
      if (v.cyc[3]) begin
         m_err = 1;
      end else begin
         exp_q.push_back(mk(1'b0, 1'b1, 4'h0));  drv_q.push_back(4'hF);
         exp_q.push_back(mk(1'b1, 1'b1, v.cyc)); drv_q.push_back(4'hF);
         n_nib = v.cyc[2] ? 8 : 4;
         for (int i = n_nib - 1; i >= 0; i--) begin
            exp_q.push_back(mk(1'b1, 1'b1, v.addr[4*i +: 4]));
            drv_q.push_back(4'hF);
         end
         if (!rd) begin
            exp_q.push_back(mk(1'b1, 1'b1, v.wdata[3:0])); drv_q.push_back(4'hF);
            exp_q.push_back(mk(1'b1, 1'b1, v.wdata[7:4])); drv_q.push_back(4'hF);
         end
         exp_q.push_back(mk(1'b1, 1'b1, 4'hF)); drv_q.push_back(4'hF);
         exp_q.push_back(mk(1'b1, 1'b0, 4'hF)); drv_q.push_back(4'hF);
         for (int k = 0; k < 4000; k++) begin
            code = (k < v.n_wait) ? v.wait_code : v.term;
            exp_q.push_back(mk(1'b1, 1'b0, 4'hF));
            drv_q.push_back(code);
            if (code == 4'h0 || code == 4'hA) begin
               term_seen = 1;
               m_err = (code == 4'hA);
               break;
            end
            cnt++;
            if (code == 4'h6) lng = 1;
            if (cnt == (lng ? LONG_TO : SYNC_TO)) begin
               aborted = 1;
               break;
            end
         end
         if (term_seen) begin
            if (rd) begin
               exp_q.push_back(mk(1'b1, 1'b0, 4'hF)); drv_q.push_back(v.rdata[3:0]);
               exp_q.push_back(mk(1'b1, 1'b0, 4'hF)); drv_q.push_back(v.rdata[7:4]);
            end
            repeat (2) begin
               exp_q.push_back(mk(1'b1, 1'b0, 4'hF)); drv_q.push_back(4'hF);
            end
         end
         if (aborted) begin
            m_tmo = 1;
            repeat (4) begin
               exp_q.push_back(mk(1'b0, 1'b1, 4'hF)); drv_q.push_back(4'hF);
            end
            exp_q.push_back(mk(1'b1, 1'b1, 4'hF)); drv_q.push_back(4'hF);
         end
      end
      exp_n  = exp_q.size() + 1;
      m_data = (term_seen && rd) ? v.rdata : hold_data;
      if (v.exp_n > 0) begin
         exp_n  = v.exp_n;
         m_err  = v.exp_err;
         m_tmo  = v.exp_tmo;
         m_data = v.exp_rdata;
      end

      check("req_ready before request", {31'd0, bus_if.req_ready}, 32'd1);
      bus_if.req_valid       = 1'b1;
      bus_if.req_cyctype_dir = v.cyc;
      bus_if.req_addr        = v.addr;
      bus_if.req_data        = v.wdata;
      @(posedge clock);
      #1;
      bus_if.req_valid = 1'b0;
      bus_if.lpc_ad_in = (drv_q.size() > 0) ? drv_q[0] : 4'hF;
      for (int c = 1; c <= exp_n; c++) begin
         @(negedge clock);
         if (c < exp_n) begin
            e = (c - 1 < exp_q.size()) ? exp_q[c-1] : mk(1'b1, 1'b0, 4'hF);
            check($sformatf("bus cyc %0d", c),
                  {25'd0, bus_if.resp_valid, bus_if.lpc_frame, bus_if.lpc_ad_oe,
                   e.oe ? bus_if.lpc_ad_out : 4'h0},
                  {25'd0, 1'b0, e.frame, e.oe, e.oe ? e.ad : 4'h0});
            @(posedge clock);
            #1;
            bus_if.lpc_ad_in = (c < drv_q.size()) ? drv_q[c] : 4'hF;
         end else begin
            check($sformatf("resp_valid cyc %0d", c), {31'd0, bus_if.resp_valid}, 32'd1);
            check("resp_error",   {31'd0, bus_if.resp_error},   {31'd0, m_err});
            check("resp_timeout", {31'd0, bus_if.resp_timeout}, {31'd0, m_tmo});
            check("resp_data",    {24'd0, bus_if.resp_data},    {24'd0, m_data});
            check("done bus idle", {30'd0, bus_if.lpc_frame, bus_if.lpc_ad_oe}, 32'd2);
         end
      end
      hold_data = m_data;
   endtask

   vec_t tbl[10];

   initial begin
      vec_t        v;
      int unsigned r;

      vectors = 0;
      miscompares = 0;
      hold_data = 8'h00;
      reset = 1'b0;
      bus_if.req_valid       = 1'b0;
      bus_if.req_cyctype_dir = 4'h0;
      bus_if.req_addr        = 32'h0;
      bus_if.req_data        = 8'h00;
      bus_if.lpc_ad_in       = 4'hF;

      //           cyc      addr          wd     nw   wc     term   rd     n     err tmo data
      tbl[0] = mkv(4'b0010, 32'h0000_0080, 8'hA5, 0,   4'h5, 4'h0, 8'h00, 14,   0,  0,  8'h00);
      tbl[1] = mkv(4'b0100, 32'hFFFF_FFF0, 8'h00, 3,   4'h5, 4'h0, 8'hC4, 21,   0,  0,  8'hC4);
      tbl[2] = mkv(4'b0000, 32'h0000_0060, 8'h00, 0,   4'hF, 4'hF, 8'h77, 22,   0,  1,  8'hC4);
      tbl[3] = mkv(4'b0000, 32'h0000_0064, 8'h00, 100, 4'h6, 4'hA, 8'h3E, 114,  1,  0,  8'h3E);
      tbl[4] = mkv(4'b1000, 32'h0000_0000, 8'h00, 0,   4'h5, 4'h0, 8'h00, 1,    1,  0,  8'h3E);
      tbl[5] = mkv(4'b0010, 32'h0000_1234, 8'h5A, 7,   4'h5, 4'h0, 8'h00, 21,   0,  0,  8'h3E);
      tbl[6] = mkv(4'b0010, 32'h0000_02F8, 8'h01, 1,   4'h6, 4'hF, 8'h00, 1040, 0,  1,  8'h3E);
      tbl[7] = mkv(4'b0110, 32'h1234_5678, 8'h9C, 0,   4'h5, 4'hA, 8'h00, 18,   1,  0,  8'h3E);
      tbl[8] = mkv(4'b1100, 32'h0000_0000, 8'h00, 0,   4'h5, 4'h0, 8'h00, 1,    1,  0,  8'h3E);
      tbl[9] = mkv(4'b0000, 32'h0000_0070, 8'h00, 8,   4'h5, 4'h0, 8'h99, 22,   0,  1,  8'h3E);

      // Reset state.
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset frame/oe/ad", {26'd0, bus_if.lpc_frame, bus_if.lpc_ad_oe, bus_if.lpc_ad_out},
            {26'd0, 1'b1, 1'b0, 4'hF});
      check("reset req_ready", {31'd0, bus_if.req_ready}, 32'd0);
      check("reset resp", {21'd0, bus_if.resp_valid, bus_if.resp_error, bus_if.resp_timeout,
                           bus_if.resp_data}, 32'd0);
      reset = 1'b1;
      @(negedge clock);
      check("req_ready after reset", {31'd0, bus_if.req_ready}, 32'd1);

      // Directed table, issued back-to-back.
      for (int i = 0; i < 10; i++) run_txn(tbl[i]);

      // Reset in the ADDR phase of a memory write.
      bus_if.req_valid       = 1'b1;
      bus_if.req_cyctype_dir = 4'b0110;
      bus_if.req_addr        = 32'hDEAD_BEEF;
      bus_if.req_data        = 8'h11;
      @(posedge clock);
      #1;
      bus_if.req_valid = 1'b0;
      repeat (3) @(negedge clock);
      check("mid-reset in ADDR", {26'd0, bus_if.lpc_frame, bus_if.lpc_ad_oe, bus_if.lpc_ad_out},
            {26'd0, 1'b1, 1'b1, 4'hD});
      reset = 1'b0;
      @(negedge clock);
      check("mid-reset bus released", {29'd0, bus_if.lpc_frame, bus_if.lpc_ad_oe, bus_if.resp_valid},
            {29'd0, 1'b1, 1'b0, 1'b0});
      check("mid-reset req_ready", {31'd0, bus_if.req_ready}, 32'd0);
      reset = 1'b1;
      @(negedge clock);
      check("req_ready after mid-reset", {30'd0, bus_if.req_ready, bus_if.resp_valid}, 32'd2);
      hold_data = 8'h00;
      run_txn(mkv(4'b0010, 32'h0000_0080, 8'h3C, 0, 4'h5, 4'h0, 8'h00, 0, 0, 0, 8'h00));

      // Random requests against the protocol model.
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 7);
         v.cyc = (r == 0) ? {2'b1, 1'($urandom), 1'($urandom)}
                          : {1'b0, 1'($urandom), 1'($urandom), 1'($urandom)};
         v.addr   = $urandom;
         v.wdata  = 8'($urandom);
         v.rdata  = 8'($urandom);
         v.n_wait = $urandom_range(0, 9);
         r = $urandom_range(0, 3);
         v.wait_code = (r == 0) ? 4'h5 : (r == 1) ? 4'h6 : (r == 2) ? 4'hF : 4'h3;
         r = $urandom_range(0, 4);
         v.term = (r < 3) ? 4'h0 : (r == 3) ? 4'hA : 4'hF;
         if (v.term == 4'hF) v.wait_code = 4'h5;
         v.exp_n = 0; v.exp_err = 0; v.exp_tmo = 0; v.exp_rdata = 8'h00;
         run_txn(v);
      end

      @(negedge clock);
      check("idle after last response", {30'd0, bus_if.resp_valid, bus_if.req_ready}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lpc_host.md
# lpc_host

LPC bus initiator: the transmit-side counterpart to the `lpc` cycle decoder. It accepts one I/O or memory read/write request at a time, drives START/CYCTYPE/ADDR/DATA/TAR on LAD[3:0] and LFRAME#, waits for the peripheral's SYNC, and returns read data and status. It runs directly in the LPC clock domain. It is used to generate known traffic for the sniffer chain and to act as host on benches with no chipset.

## Interface
- `SYNC_TIMEOUT`, default 8: SYNC cycles allowed without a ready/error code before abort (no long wait seen).
- `LONG_TIMEOUT`, default 1024: the same limit once long wait (0110) has been seen in this cycle.
- `clock` input 1: LPC clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: block idle and accepting. A transfer happens when `req_valid & req_ready`.
- `req_cyctype_dir` input 4: CYCTYPE+DIR nibble, same encoding as the `lpc` decoder output.
  - [3:2]: 00 = I/O, 01 = memory.
  - [1]: 1 = write.
  - [0]: driven on bus as given.
- `req_addr` input 32: address. I/O uses [15:0].
- `req_data` input 8: write data.
- `resp_valid` output 1: one-cycle pulse at the end of every accepted request.
- `resp_data` output 8: read data. Holds its value until the next `resp_valid`.
- `resp_error` output 1: qualifies `resp_valid`. Set by error SYNC (1010) or an unsupported cycle type.
- `resp_timeout` output 1: qualifies `resp_valid`. Set when the cycle was aborted.
- `lpc_ad_in` input 4: sampled LAD.
- `lpc_ad_out` output 4: LAD drive value.
- `lpc_ad_oe` output 1: LAD output enable.
- `lpc_frame` output 1: LFRAME#, active-low.

## Operation
- Reset values:
  - `lpc_frame`=1, `lpc_ad_oe`=0, `lpc_ad_out`=4'hF.
  - `req_ready`=0 while reset is asserted; 1 in the first cycle after reset deasserts.
  - `resp_valid`=0, `resp_error`=0, `resp_timeout`=0, `resp_data`=0.
- On acceptance, all request fields are registered and `req_ready` drops.
- States: IDLE, START, CYCTYPE, ADDR, HDATA, TAR_H, SYNC, PDATA, TAR_P, ABORT, DONE.
- START (1 cycle): `lpc_frame`=0, AD=0000, oe=1.
- CYCTYPE (1): `lpc_frame`=1, AD=`req_cyctype_dir`.
- ADDR: 4 nibbles for I/O, 8 for memory, most-significant nibble first.
- HDATA (writes only, 2 cycles): data low nibble, then high nibble.
- TAR_H (2 cycles): first cycle drives 1111, oe=1; second cycle oe=0.
- SYNC: oe=0. Sample `lpc_ad_in` every cycle.
  - 0000 (ready) or 1010 (error): terminal. Go to PDATA for reads, TAR_P for writes. 1010 latches `resp_error`.
  - 0101 (short wait), 0110 (long wait), 1111 (no response) and any other code: stay in SYNC and count.
  - 0110 switches the limit from `SYNC_TIMEOUT` to `LONG_TIMEOUT` for the rest of the cycle.
  - The counter clears on entry to SYNC. When the count reaches the limit without a terminal code, go to ABORT.
- PDATA (reads, 2 cycles): capture low nibble, then high nibble, into `resp_data`. Also done after error SYNC.
- TAR_P (2 cycles): oe=0, `lpc_frame`=1.
- ABORT:
  - 4 cycles of `lpc_frame`=0 with AD=1111, oe=1.
  - Then 1 cycle of `lpc_frame`=1 with oe=1, AD=1111.
  - Then go to DONE with `resp_timeout`=1.
- Unsupported type ([3:2]=10 or 11): no bus activity. Go to DONE next cycle with `resp_error`=1.
- DONE (1 cycle):
  - `resp_valid`=1, `req_ready`=1. A new request may be accepted in this cycle.
  - `resp_error`/`resp_timeout` are valid only here and clear when the next request is accepted.
- Reset asserted mid-cycle: bus released on the next edge (frame=1, oe=0), state IDLE, no `resp_valid`.

## Timing
- Bus cycle 1 (START) is the cycle after the acceptance edge.
- Total bus cycles N, with SYNC ready on its first cycle:
  - I/O read and I/O write: 13.
  - Memory read and memory write: 17.
- Each extra wait cycle adds 1 to N.
- `resp_valid` is asserted in cycle N+1.
- Abort length after the timeout cycle: 5 bus cycles, then DONE.
- Back-to-back: a request held on `req_valid` is accepted in DONE, so START follows DONE immediately. No idle gap is required.
- `lpc_ad_oe` is never 1 in TAR_H cycle 2, SYNC, PDATA or TAR_P.

## Test plan
- I/O write, addr 0x0080, data 0xA5, peripheral SYNC 0000 immediately:
  - LAD sequence 0000,0010,0,0,8,0, 5,A, F, then released.
  - `resp_valid` in cycle 14; `resp_error`=0.
- Memory read, addr 0xFFFF_FFF0, peripheral 0101 ×3 then 0000, data nibbles 4 then C:
  - `resp_data`=0xC4; `resp_valid` in cycle 21.
- No response (LAD=1111 forever), I/O read, `SYNC_TIMEOUT`=8:
  - 8 SYNC cycles, then 4 cycles of LFRAME# low with AD=F, 1 recovery cycle.
  - `resp_timeout`=1, `resp_data` unchanged.
- Long wait: 0110 ×100, then 1010, I/O read, data 0x3E:
  - No abort; `resp_error`=1; `resp_data`=0x3E.
- `req_cyctype_dir`=4'b1000:
  - `lpc_frame` stays 1, oe stays 0.
  - `resp_valid` with `resp_error`=1 one cycle after acceptance.
- Reset low during ADDR of a memory write:
  - Next edge: `lpc_frame`=1, oe=0, no `resp_valid`.
  - `req_ready`=1 in the first cycle after reset deasserts, and a following I/O write completes normally.
